pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline controller for the 5-stage RV32 core. Sequences the enable and flush inputs of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. Resolves load-use stalls, taken-branch flushes and multi-cycle data-memory waits. Raises a sticky error and halts the pipeline when a data-memory access times out. Also keeps saturating stall and flush statistics counters.

## Interface
- `regindex`, default 5: register index width.
- `MEM_TIMEOUT`, default 16: maximum consecutive data-memory stall cycles before HALT; legal range ≥ 2.
- `CNTW`, default 16: width of the statistics counters.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `id_rs1`, `id_rs2` in `regindex`: source register indices of the instruction in ID.
- `id_use_rs1`, `id_use_rs2` in 1: that source is actually read.
- `ex_rd` in `regindex`: destination register index of the instruction in EX.
- `ex_memread` in 1: the instruction in EX is a load.
- `ex_branch_taken` in 1: a branch or jump in EX redirects the PC this cycle.
- `mem_req` in 1: the instruction in MEM is accessing data memory.
- `dmem_ready` in 1: data memory completes the access this cycle.
- `pc_en`, `ifid_en`, `idex_en`, `exmem_en`, `memwb_en` out 1: register load enables.
- `ifid_flush`, `idex_flush`, `exmem_flush`, `memwb_flush` out 1: synchronous clear to a bubble. Flush overrides en in the register.
- `mem_err` out 1: sticky timeout error.
- `stall_cnt`, `flush_cnt` out `CNTW`: saturating statistics counters.

## Operation
- States: FLUSH, RUN, MEM_WAIT, HALT. Outputs are Mealy, derived combinationally from the current state and inputs.
- FLUSH: all `*_en`=1, all `*_flush`=1, `pc_en`=0. Lasts exactly one cycle, then RUN.
- RUN and MEM_WAIT resolve conditions in this priority order:
  1. Memory stall (`mem_req` & ~`dmem_ready`):
     - `pc_en`, `ifid_en`, `idex_en`, `exmem_en` = 0, with no flush on those registers.
     - `memwb_en`=1 and `memwb_flush`=1, so a bubble enters WB.
  2. Branch taken (`ex_branch_taken`):
     - All enables 1; `ifid_flush`=1 and `idex_flush`=1.
     - `flush_cnt` += 1.
  3. Load-use: `ex_memread` & (`ex_rd`≠0) & ((`id_use_rs1` & `id_rs1`==`ex_rd`) | (`id_use_rs2` & `id_rs2`==`ex_rd`)).
     - `pc_en`=0, `ifid_en`=0, `idex_flush`=1; all other enables 1.
  4. Otherwise: all enables 1, all flushes 0.
- `stall_cnt` increments on every cycle where case 1 or case 3 applies.
- Both statistics counters saturate at 2^CNTW−1; they never wrap.
- Transitions:
  - RUN→MEM_WAIT on a memory stall; `wait_cnt` is loaded with 1.
  - MEM_WAIT→RUN when `dmem_ready`=1 or `mem_req`=0. Normal case 2–4 resolution applies in that same cycle.
  - MEM_WAIT with the stall still present: `wait_cnt` += 1.
  - MEM_WAIT→HALT at the edge that ends the MEM_TIMEOUT-th consecutive stalled cycle.
- HALT:
  - All `*_en`=0 and all `*_flush`=0; `mem_err`=1.
  - All inputs, including `dmem_ready`, are ignored.
  - Only reset leaves HALT.

## Timing
- While `rst`=0 (asynchronous):
  - state = FLUSH, `wait_cnt`=0, counters=0, `mem_err`=0.
  - Outputs: `pc_en`=0, other enables 1, all flushes 1.
- The first edge after `rst` deasserts completes the FLUSH cycle; RUN starts the following cycle.
- Zero latency from inputs to enable/flush outputs (same cycle).
- Counters and `mem_err` update at the edge ending the qualifying cycle.
- A zero-wait access (`mem_req` and `dmem_ready` high together) does not stall and does not leave RUN.
- Branch and memory stall in the same cycle: the branch is held, not flushed, and `flush_cnt` is not incremented. The branch is taken on the release cycle.
- Reset asserted mid-MEM_WAIT or during HALT returns to FLUSH immediately and clears `mem_err`.

## Structure
- Package `pipe_ctrl_pkg` holds:
  - the state encoding (FLUSH=2'd0, RUN=2'd1, MEM_WAIT=2'd2, HALT=2'd3);
  - the default `MEM_TIMEOUT`;
  - the default `CNTW`.
- Sub-module `sat_counter` (parameter width, inputs `inc`/`clk`/`rst`, output count) is instantiated twice, for `stall_cnt` and `flush_cnt`.
- The hazard compare logic and the FSM live in `pipe_ctrl` itself.

## Test plan
- Reset release: hold `rst`=0 for 3 cycles, then release → FLUSH outputs during reset and for one cycle after (`pc_en`=0, all flushes 1), then RUN with all enables 1 and all flushes 0.
- Load-use: `ex_memread`=1, `ex_rd`=5, `id_rs2`=5, `id_use_rs2`=1 → `pc_en`=0, `ifid_en`=0, `idex_flush`=1, and `stall_cnt` reads 1 next cycle. Repeat with `ex_rd`=0 → no stall.
- Branch flush: `ex_branch_taken`=1 for 1 cycle → `ifid_flush`=`idex_flush`=1, `pc_en`=1, `flush_cnt`=1.
- Memory wait: `mem_req`=1 with `dmem_ready` low for 3 cycles, then high → 3 cycles frozen with `memwb_flush`=1, state returns to RUN, `stall_cnt`=3. Add a simultaneous branch → branch flush occurs only on the release cycle.
- Timeout: `mem_req`=1, `dmem_ready`=0 with `MEM_TIMEOUT`=16 → HALT after 16 stalled cycles, `mem_err`=1, all enables 0. A later `dmem_ready`=1 has no effect; asserting `rst`=0 clears `mem_err`.
- Saturation: `CNTW`=4, 20 consecutive load-use cycles → `stall_cnt` holds at 15.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the 5-stage pipeline controller.
// State encoding is fixed so external monitors can decode state_dbg.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        FLUSH    = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2,
        HALT     = 2'd3
    } state_t;

    localparam int DEF_MEM_TIMEOUT = 16;
    localparam int DEF_CNTW        = 16;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard inputs from the datapath and register enable/flush controls back to it.
// Data memory: an access completes in the cycle where mem_req and dmem_ready are both high; mem_req without dmem_ready is a wait cycle.
interface pipe_ctrl_if #(parameter int regindex = 5);

    logic [regindex-1:0] id_rs1;
    logic [regindex-1:0] id_rs2;
    logic                id_use_rs1;
    logic                id_use_rs2;
    logic [regindex-1:0] ex_rd;
    logic                ex_memread;
    logic                ex_branch_taken;
    logic                mem_req;
    logic                dmem_ready;

    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic memwb_flush;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memread,
               ex_branch_taken, mem_req, dmem_ready,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, memwb_flush
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memread,
               ex_branch_taken, mem_req, dmem_ready,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, memwb_flush
    );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int width = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [width-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: load-use stalls, branch flushes, data-memory waits
// with timeout to a sticky HALT, plus stall/flush statistics.
import pipe_ctrl_pkg::*;

module pipe_ctrl #(
    parameter int regindex    = 5,
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
    parameter int CNTW        = DEF_CNTW
) (
    input  logic            clk,
    input  logic            rst,
    pipe_ctrl_if.slave      bus,
    output logic            mem_err,
    output logic [CNTW-1:0] stall_cnt,
    output logic [CNTW-1:0] flush_cnt,
    output state_t          state_dbg
);

    localparam int WW = $clog2(MEM_TIMEOUT + 1);

    state_t        state, state_nxt;
    logic [WW-1:0] wait_cnt, wait_nxt;
    logic          err_nxt;

    logic [regindex-1:0] rs1, rs2, rd;
    logic mem_stall, load_use;
    logic stall_inc, flush_inc;
    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic ifid_flush, idex_flush, exmem_flush, memwb_flush;

    assign rs1 = bus.id_rs1;
    assign rs2 = bus.id_rs2;
    assign rd  = bus.ex_rd;

    assign mem_stall = bus.mem_req & ~bus.dmem_ready;
    // x0 is never a real dependency, so a load targeting it cannot stall.
    assign load_use  = bus.ex_memread & (rd != '0) &
                       ((bus.id_use_rs1 & (rs1 == rd)) |
                        (bus.id_use_rs2 & (rs2 == rd)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= FLUSH;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            mem_err  <= err_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        wait_nxt    = wait_cnt;
        err_nxt     = mem_err;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;

        case (state)
            FLUSH: begin
                {ifid_en, idex_en, exmem_en, memwb_en}             = 4'b1111;
                {ifid_flush, idex_flush, exmem_flush, memwb_flush} = 4'b1111;
                state_nxt = RUN;
            end
            RUN, MEM_WAIT: begin
                if (mem_stall) begin
                    // Freeze everything upstream of WB; a pending branch waits here too.
                    memwb_en    = 1'b1;
                    memwb_flush = 1'b1;
                    stall_inc   = 1'b1;
                    if (state == RUN) begin
                        state_nxt = MEM_WAIT;
                        wait_nxt  = WW'(1);
                    end else if (wait_cnt == WW'(MEM_TIMEOUT - 1)) begin
                        state_nxt = HALT;
                        wait_nxt  = '0;
                        err_nxt   = 1'b1;
                    end else begin
                        wait_nxt = wait_cnt + 1'b1;
                    end
                end else begin
                    state_nxt = RUN;
                    wait_nxt  = '0;
                    {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
                    if (bus.ex_branch_taken) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                        flush_inc  = 1'b1;
                    end else if (load_use) begin
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        idex_flush = 1'b1;
                        stall_inc  = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = HALT;
            end
        endcase
    end

    assign bus.pc_en       = pc_en;
    assign bus.ifid_en     = ifid_en;
    assign bus.idex_en     = idex_en;
    assign bus.exmem_en    = exmem_en;
    assign bus.memwb_en    = memwb_en;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.idex_flush  = idex_flush;
    assign bus.exmem_flush = exmem_flush;
    assign bus.memwb_flush = memwb_flush;
    assign state_dbg       = state;

    sat_counter #(.width(CNTW)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.width(CNTW)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: two instances (default and small timeout/counter width)
// share stimulus and are compared every cycle against a behavioural model.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int TMO_A = 16;
    localparam int TMO_B = 4;
    localparam int MAX_A = 65535;
    localparam int MAX_B = 15;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic id_use_rs1 = 0, id_use_rs2 = 0, ex_memread = 0;
    logic ex_branch_taken = 0, mem_req = 0, dmem_ready = 0;

    pipe_ctrl_if #(.regindex(5)) bus_a ();
    pipe_ctrl_if #(.regindex(5)) bus_b ();

    assign bus_a.id_rs1 = id_rs1;           assign bus_b.id_rs1 = id_rs1;
    assign bus_a.id_rs2 = id_rs2;           assign bus_b.id_rs2 = id_rs2;
    assign bus_a.id_use_rs1 = id_use_rs1;   assign bus_b.id_use_rs1 = id_use_rs1;
    assign bus_a.id_use_rs2 = id_use_rs2;   assign bus_b.id_use_rs2 = id_use_rs2;
    assign bus_a.ex_rd = ex_rd;             assign bus_b.ex_rd = ex_rd;
    assign bus_a.ex_memread = ex_memread;   assign bus_b.ex_memread = ex_memread;
    assign bus_a.ex_branch_taken = ex_branch_taken;
    assign bus_b.ex_branch_taken = ex_branch_taken;
    assign bus_a.mem_req = mem_req;         assign bus_b.mem_req = mem_req;
    assign bus_a.dmem_ready = dmem_ready;   assign bus_b.dmem_ready = dmem_ready;

    logic        err_a, err_b;
    logic [15:0] scnt_a, fcnt_a;
    logic [3:0]  scnt_b, fcnt_b;
    state_t      st_a, st_b;

    pipe_ctrl #(.regindex(5), .MEM_TIMEOUT(TMO_A), .CNTW(16)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a), .mem_err(err_a),
        .stall_cnt(scnt_a), .flush_cnt(fcnt_a), .state_dbg(st_a)
    );

    pipe_ctrl #(.regindex(5), .MEM_TIMEOUT(TMO_B), .CNTW(4)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b), .mem_err(err_b),
        .stall_cnt(scnt_b), .flush_cnt(fcnt_b), .state_dbg(st_b)
    );

    // ---------------- clock ----------------
    initial forever #5 clk = ~clk;

    // ---------------- check bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // {pc, ifid, idex, exmem, memwb enables, ifid, idex, exmem, memwb flushes}
    function automatic logic [8:0] ctrl_a();
        return {bus_a.pc_en, bus_a.ifid_en, bus_a.idex_en, bus_a.exmem_en, bus_a.memwb_en,
                bus_a.ifid_flush, bus_a.idex_flush, bus_a.exmem_flush, bus_a.memwb_flush};
    endfunction

    function automatic logic [8:0] ctrl_b();
        return {bus_b.pc_en, bus_b.ifid_en, bus_b.idex_en, bus_b.exmem_en, bus_b.memwb_en,
                bus_b.ifid_flush, bus_b.idex_flush, bus_b.exmem_flush, bus_b.memwb_flush};
    endfunction

    // ---------------- behavioural model + compare process ----------------
    bit m_first[2] = '{1, 1};
    bit m_halt[2]  = '{0, 0};
    int m_consec[2] = '{0, 0};
    int m_scnt[2]   = '{0, 0};
    int m_fcnt[2]   = '{0, 0};

    always @(negedge clk) begin
        logic [8:0] exp_ctrl;
        int exp_state, tmo, cmax;
        int act_ctrl, act_state, act_err, act_s, act_f;
        bit ms, lu;
        ms = mem_req && !dmem_ready;
        lu = ex_memread && (ex_rd != 0) &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        for (int i = 0; i < 2; i++) begin
            tmo  = (i == 0) ? TMO_A : TMO_B;
            cmax = (i == 0) ? MAX_A : MAX_B;
            if (!rst) begin
                m_first[i] = 1; m_halt[i] = 0; m_consec[i] = 0;
                m_scnt[i] = 0; m_fcnt[i] = 0;
            end
            if (m_first[i])       begin exp_ctrl = 9'b011111111; exp_state = 0; end
            else if (m_halt[i])   begin exp_ctrl = 9'b000000000; exp_state = 3; end
            else begin
                exp_state = (m_consec[i] > 0) ? 2 : 1;
                if (ms)                   exp_ctrl = 9'b000010001;
                else if (ex_branch_taken) exp_ctrl = 9'b111111100;
                else if (lu)              exp_ctrl = 9'b001110100;
                else                      exp_ctrl = 9'b111110000;
            end
            act_ctrl  = (i == 0) ? int'(ctrl_a()) : int'(ctrl_b());
            act_state = (i == 0) ? int'(st_a) : int'(st_b);
            act_err   = (i == 0) ? int'(err_a) : int'(err_b);
            act_s     = (i == 0) ? int'(scnt_a) : int'(scnt_b);
            act_f     = (i == 0) ? int'(fcnt_a) : int'(fcnt_b);
            chk($sformatf("ctrl[%0d]", i), act_ctrl, int'(exp_ctrl));
            chk($sformatf("state[%0d]", i), act_state, exp_state);
            chk($sformatf("mem_err[%0d]", i), act_err, int'(m_halt[i]));
            chk($sformatf("stall_cnt[%0d]", i), act_s, m_scnt[i]);
            chk($sformatf("flush_cnt[%0d]", i), act_f, m_fcnt[i]);
            // advance the model to what the next rising edge produces
            if (rst) begin
                if (m_first[i]) m_first[i] = 0;
                else if (!m_halt[i]) begin
                    if (ms) begin
                        m_consec[i]++;
                        if (m_scnt[i] < cmax) m_scnt[i]++;
                        if (m_consec[i] == tmo) begin m_halt[i] = 1; m_consec[i] = 0; end
                    end else begin
                        m_consec[i] = 0;
                        if (ex_branch_taken) begin if (m_fcnt[i] < cmax) m_fcnt[i]++; end
                        else if (lu)         begin if (m_scnt[i] < cmax) m_scnt[i]++; end
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic go();
        @(posedge clk); #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    task automatic idle();
        id_rs1 = 0; id_rs2 = 0; ex_rd = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_memread = 0; ex_branch_taken = 0; mem_req = 0; dmem_ready = 0;
    endtask

    task automatic set_load_use();
        ex_memread = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1; id_rs1 = 3; id_use_rs1 = 1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        idle();
        rst = 0;
        repeat (3) begin
            look();
            chk("rst_pc_en", int'(bus_a.pc_en), 0);
            chk("rst_flushes", int'({bus_a.ifid_flush, bus_a.idex_flush,
                                     bus_a.exmem_flush, bus_a.memwb_flush}), 4'hF);
        end
        go(); rst = 1;
        look();
        chk("flush_cycle_ctrl", int'(ctrl_a()), 9'h0FF);
        go(); look();
        chk("run_ctrl", int'(ctrl_a()), 9'h1F0);
        chk("run_state", int'(st_a), 1);

        // load-use, then the same with ex_rd = x0
        go(); set_load_use();
        look();
        chk("lu_pc_en", int'(bus_a.pc_en), 0);
        chk("lu_ifid_en", int'(bus_a.ifid_en), 0);
        chk("lu_idex_flush", int'(bus_a.idex_flush), 1);
        go(); ex_rd = 0; id_rs2 = 0;
        look();
        chk("lu_stall_cnt", int'(scnt_a), 1);
        chk("lu_x0_pc_en", int'(bus_a.pc_en), 1);

        // branch flush
        go(); idle(); ex_branch_taken = 1;
        look();
        chk("br_flushes", int'({bus_a.ifid_flush, bus_a.idex_flush}), 2'b11);
        chk("br_pc_en", int'(bus_a.pc_en), 1);
        go(); ex_branch_taken = 0;
        look();
        chk("br_flush_cnt", int'(fcnt_a), 1);

        // three wait cycles with a branch held, then release
        go(); mem_req = 1; dmem_ready = 0; ex_branch_taken = 1;
        for (int k = 0; k < 3; k++) begin
            look();
            chk("mw_frozen", int'(ctrl_a()), 9'h011);
            go();
        end
        dmem_ready = 1;
        look();
        chk("mw_release_ctrl", int'(ctrl_a()), 9'h1FC);
        chk("mw_release_state", int'(st_a), 2);
        go(); idle();
        look();
        chk("mw_back_run", int'(st_a), 1);
        chk("mw_stall_cnt", int'(scnt_a), 4);
        chk("mw_flush_cnt", int'(fcnt_a), 2);

        // timeout to HALT
        go(); mem_req = 1; dmem_ready = 0;
        for (int k = 1; k <= TMO_A; k++) begin
            look();
            if (k == TMO_A) chk("tmo_last_wait", int'(st_a), 2);
            go();
        end
        look();
        chk("halt_state", int'(st_a), 3);
        chk("halt_err", int'(err_a), 1);
        chk("halt_ctrl", int'(ctrl_a()), 0);
        chk("halt_stall_cnt", int'(scnt_a), 20);
        go(); dmem_ready = 1;
        look();
        chk("halt_ignores_ready", int'(st_a), 3);
        go(); rst = 0; #1;
        chk("async_rst_state", int'(st_a), 0);
        chk("async_rst_err", int'(err_a), 0);
        go(); rst = 1; idle();

        // saturation on the 4-bit instance
        go(); set_load_use();
        repeat (20) go();
        idle();
        look();
        chk("sat_b_stall", int'(scnt_b), 15);
        chk("sat_a_stall", int'(scnt_a), 20);

        // randomized traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            go();
            id_rs1 = 5'($urandom_range(0, 3));
            id_rs2 = 5'($urandom_range(0, 3));
            ex_rd  = 5'($urandom_range(0, 3));
            id_use_rs1 = 1'($urandom_range(0, 1));
            id_use_rs2 = 1'($urandom_range(0, 1));
            ex_memread = ($urandom_range(0, 2) == 0);
            ex_branch_taken = ($urandom_range(0, 5) == 0);
            mem_req    = ($urandom_range(0, 2) == 0) ? ~mem_req : mem_req;
            dmem_ready = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 249) != 0);
        end
        go(); rst = 1; idle();
        look();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
